// File: rtl/con_stream_pkg.sv
// con_stream_pkg
//   Shared types and sizing helpers for the con_stream feeder.
//   feeder_state_t : issue FSM states.
//   ceil_div       : integer ceiling division (channel-group count).
//   row_stride     : words per feature-map row (preload block + all pixel blocks).
//   total_words    : words emitted by one complete stream.
package con_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        KERNEL,
        PRELOAD,
        PIXEL,
        DRAIN
    } feeder_state_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    function automatic int unsigned row_stride(input int unsigned preload_words,
                                               input int unsigned fm_width,
                                               input int unsigned pixel_words);
        return preload_words + fm_width * pixel_words;
    endfunction

    function automatic int unsigned total_words(input int unsigned groups,
                                                input int unsigned ch_out_par,
                                                input int unsigned kernel_words,
                                                input int unsigned fm_height,
                                                input int unsigned preload_words,
                                                input int unsigned fm_width,
                                                input int unsigned pixel_words);
        return groups * (ch_out_par * kernel_words
                         + fm_height * row_stride(preload_words, fm_width, pixel_words));
    endfunction

endpackage

// File: rtl/con_stream_fifo.sv
// con_stream_fifo
//   2-entry FIFO with registered outputs; dout/valid come straight from flops,
//   so the consumer side never sees a combinational path from push or pop.
//   clk, srst_in : clock, synchronous active-high reset
//   push, din    : write one word
//   pop          : remove the head word (ignored when empty)
//   dout, valid  : head word and its presence
//   count        : number of stored words (0..2)
module con_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  srst_in,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] head_q;
    logic [DATA_WIDTH-1:0] tail_q;
    logic [1:0]            count_q;
    logic                  valid_q;
    logic                  pop_ok;

    assign pop_ok = pop && (count_q != 2'd0);

    always_ff @(posedge clk) begin
        if (srst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            case ({push, pop_ok})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= din;
                    else                 tail_q <= din;
                    count_q <= count_q + 2'd1;
                    valid_q <= 1'b1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                    valid_q <= (count_q == 2'd2);
                end
                2'b11: begin
                    // Occupancy unchanged; with one entry the new word becomes head.
                    if (count_q == 2'd1) begin
                        head_q <= din;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    // The read-credit rule upstream must never let a word arrive into a full FIFO.
    always_ff @(posedge clk) begin
        if (!srst_in) begin
            overflow_chk: assert (!(push && !pop_ok && count_q == 2'd2));
        end
    end

    assign dout  = head_q;
    assign valid = valid_q;
    assign count = count_q;

endmodule

// File: rtl/con_stream_feeder.sv
// con_stream_feeder
//   Producer end of the device's con_valid/con_ready input stream. Reads kernel
//   and feature-map words from a 1-cycle-latency memory and emits them in the
//   order the device consumes them: per output-channel group the kernel words,
//   then for every row a preload block followed by one block per pixel.
//   clk, srst_in          : clock, synchronous active-high reset
//   start                 : begin one full stream (honoured in IDLE only)
//   running, done         : stream in progress / pulse on acceptance of the final word
//   mem_re, mem_addr      : memory read request
//   mem_rdata             : read data, one cycle after mem_re
//   con_valid, con_ready,
//   con_data              : output stream handshake
module con_stream_feeder
    import con_stream_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 32,
    parameter int unsigned ADDR_WIDTH         = 20,
    parameter int unsigned FEATURE_MAP_WIDTH  = 1024,
    parameter int unsigned FEATURE_MAP_HEIGHT = 1024,
    parameter int unsigned OUTPUT_NB_CHANNELS = 64,
    parameter int unsigned CH_OUT_PAR         = 6,
    parameter int unsigned KERNEL_WORDS       = 12,
    parameter int unsigned PRELOAD_WORDS      = 12,
    parameter int unsigned PIXEL_WORDS        = 4,
    parameter int unsigned KERNEL_BASE        = 0,
    parameter int unsigned FM_BASE            = 65536
) (
    input  logic                  clk,
    input  logic                  srst_in,
    input  logic                  start,
    output logic                  running,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  con_valid,
    input  logic                  con_ready,
    output logic [DATA_WIDTH-1:0] con_data
);

    localparam int unsigned GROUPS  = ceil_div(OUTPUT_NB_CHANNELS, CH_OUT_PAR);
    localparam int unsigned K_WORDS = CH_OUT_PAR * KERNEL_WORDS;

    feeder_state_t         state_q;
    logic [31:0]           g_q;
    logic [31:0]           y_q;
    logic [31:0]           x_q;
    logic [31:0]           w_q;
    logic [ADDR_WIDTH-1:0] kaddr_q;
    logic [ADDR_WIDTH-1:0] faddr_q;
    logic                  running_q;
    logic                  done_q;
    logic                  vld_p1;

    logic                  last_w;
    logic                  last_x;
    logic                  last_y;
    logic                  last_g;
    logic                  pop;
    logic                  issue;
    logic                  drain_done;
    logic [2:0]            occ;
    logic [1:0]            fifo_count;
    logic                  fifo_valid;
    logic [DATA_WIDTH-1:0] fifo_dout;

    // Stage p0: read issue

    always_comb begin
        last_w = 1'b0;
        case (state_q)
            KERNEL:  last_w = (w_q == K_WORDS - 1);
            PRELOAD: last_w = (w_q == PRELOAD_WORDS - 1);
            PIXEL:   last_w = (w_q == PIXEL_WORDS - 1);
            default: last_w = 1'b0;
        endcase
    end

    assign last_x = (x_q == FEATURE_MAP_WIDTH - 1);
    assign last_y = (y_q == FEATURE_MAP_HEIGHT - 1);
    assign last_g = (g_q == GROUPS - 1);

    assign pop = fifo_valid && con_ready;

    // Occupancy the FIFO will hold after this edge if no new read is issued;
    // counting the word leaving now keeps reads flowing at one per cycle.
    assign occ   = 3'(fifo_count) + 3'(vld_p1) - 3'(pop);
    assign issue = (state_q inside {KERNEL, PRELOAD, PIXEL}) && (occ < 3'd2);

    // Kernel words of successive groups are contiguous, and preload/pixel blocks
    // of successive rows tile the feature map with stride PRELOAD + W*PIXEL, so two
    // running addresses (wrapping in ADDR_WIDTH) reproduce the per-block formulas.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            KERNEL:         mem_addr = kaddr_q;
            PRELOAD, PIXEL: mem_addr = faddr_q;
            default:        mem_addr = '0;
        endcase
    end

    assign mem_re = issue;

    // The final word leaves when the FIFO holds only it and nothing is in flight.
    assign drain_done = !vld_p1 && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    always_ff @(posedge clk) begin
        if (srst_in) begin
            state_q   <= IDLE;
            g_q       <= '0;
            y_q       <= '0;
            x_q       <= '0;
            w_q       <= '0;
            kaddr_q   <= '0;
            faddr_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= KERNEL;
                        running_q <= 1'b1;
                        g_q       <= '0;
                        y_q       <= '0;
                        x_q       <= '0;
                        w_q       <= '0;
                        kaddr_q   <= ADDR_WIDTH'(KERNEL_BASE);
                        faddr_q   <= ADDR_WIDTH'(FM_BASE);
                    end
                end
                KERNEL: begin
                    if (issue) begin
                        kaddr_q <= kaddr_q + 1'b1;
                        if (last_w) begin
                            w_q     <= '0;
                            y_q     <= '0;
                            state_q <= PRELOAD;
                        end else begin
                            w_q <= w_q + 32'd1;
                        end
                    end
                end
                PRELOAD: begin
                    if (issue) begin
                        faddr_q <= faddr_q + 1'b1;
                        if (last_w) begin
                            w_q     <= '0;
                            x_q     <= '0;
                            state_q <= PIXEL;
                        end else begin
                            w_q <= w_q + 32'd1;
                        end
                    end
                end
                PIXEL: begin
                    if (issue) begin
                        faddr_q <= faddr_q + 1'b1;
                        if (last_w) begin
                            w_q <= '0;
                            if (!last_x) begin
                                x_q <= x_q + 32'd1;
                            end else if (!last_y) begin
                                y_q     <= y_q + 32'd1;
                                state_q <= PRELOAD;
                            end else if (!last_g) begin
                                // Every channel group re-reads the whole feature map.
                                g_q     <= g_q + 32'd1;
                                faddr_q <= ADDR_WIDTH'(FM_BASE);
                                state_q <= KERNEL;
                            end else begin
                                state_q <= DRAIN;
                            end
                        end else begin
                            w_q <= w_q + 32'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_done) begin
                        done_q    <= 1'b1;
                        running_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Stage p1: read data return into the output FIFO

    always_ff @(posedge clk) begin
        if (srst_in) vld_p1 <= 1'b0;
        else         vld_p1 <= issue;
    end

    con_stream_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .srst_in (srst_in),
        .push    (vld_p1),
        .din     (mem_rdata),
        .pop     (pop),
        .dout    (fifo_dout),
        .valid   (fifo_valid),
        .count   (fifo_count)
    );

    assign running   = running_q;
    assign done      = done_q;
    assign con_valid = fifo_valid;
    assign con_data  = fifo_dout;

endmodule

// File: tb/tb_con_stream_feeder.sv
// tb_con_stream_feeder
//   Two feeders (one and two channel groups) on a small 2x2 feature map, each
//   reading a memory whose words are a scrambled function of their address.
//   The expected stream is built from the nested group/row/pixel loops.
module tb_con_stream_feeder;

    localparam int DW  = 32;
    localparam int AW  = 20;
    localparam int FMW = 2;
    localparam int FMH = 2;
    localparam int CP  = 6;
    localparam int KW  = 12;
    localparam int PLW = 12;
    localparam int PXW = 4;
    localparam int KB  = 0;
    localparam int FB  = 65536;
    localparam int RS  = PLW + FMW * PXW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst, start, rdy, sel;

    logic          a_start, a_running, a_done, a_re, a_valid;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_rdata, a_data;
    logic          b_start, b_running, b_done, b_re, b_valid;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_rdata, b_data;

    assign a_start = start & ~sel;
    assign b_start = start & sel;

    con_stream_feeder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
        .OUTPUT_NB_CHANNELS(6), .CH_OUT_PAR(CP), .KERNEL_WORDS(KW), .PRELOAD_WORDS(PLW),
        .PIXEL_WORDS(PXW), .KERNEL_BASE(KB), .FM_BASE(FB)
    ) u_a (
        .clk(clk), .srst_in(srst), .start(a_start), .running(a_running), .done(a_done),
        .mem_re(a_re), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .con_valid(a_valid), .con_ready(rdy), .con_data(a_data)
    );

    con_stream_feeder #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FEATURE_MAP_WIDTH(FMW), .FEATURE_MAP_HEIGHT(FMH),
        .OUTPUT_NB_CHANNELS(12), .CH_OUT_PAR(CP), .KERNEL_WORDS(KW), .PRELOAD_WORDS(PLW),
        .PIXEL_WORDS(PXW), .KERNEL_BASE(KB), .FM_BASE(FB)
    ) u_b (
        .clk(clk), .srst_in(srst), .start(b_start), .running(b_running), .done(b_done),
        .mem_re(b_re), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .con_valid(b_valid), .con_ready(rdy), .con_data(b_data)
    );

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return {12'hA5C, a} ^ {a, 12'h000};
    endfunction

    always @(posedge clk) begin
        a_rdata <= mem_word(a_addr);
        b_rdata <= mem_word(b_addr);
    end

    logic          m_valid, m_running, m_done, m_re;
    logic [DW-1:0] m_data;
    assign m_valid   = sel ? b_valid   : a_valid;
    assign m_running = sel ? b_running : a_running;
    assign m_done    = sel ? b_done    : a_done;
    assign m_re      = sel ? b_re      : a_re;
    assign m_data    = sel ? b_data    : a_data;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    logic [DW-1:0] exp_q[$];

    function automatic void build_exp(input int groups);
        exp_q.delete();
        for (int g = 0; g < groups; g++) begin
            for (int k = 0; k < CP * KW; k++)
                exp_q.push_back(mem_word(AW'(KB + g * CP * KW + k)));
            for (int y = 0; y < FMH; y++) begin
                for (int i = 0; i < PLW; i++)
                    exp_q.push_back(mem_word(AW'(FB + y * RS + i)));
                for (int x = 0; x < FMW; x++)
                    for (int j = 0; j < PXW; j++)
                        exp_q.push_back(mem_word(AW'(FB + y * RS + PLW + x * PXW + j)));
            end
        end
    endfunction

    // rdy_mode: 0 always ready, 1 random ready, 2 ready held low 20 cycles from first valid.
    // rst_at / restart_at: word count at which to reset / pulse start again (-1 = never).
    task automatic run_stream(input string nm, input logic use_b, input int rdy_mode,
                              input int rst_at, input int restart_at);
        int idx, cyc, dones, first_v, stall_left, early_re, total;
        logic pv, r, stop, restarted;
        logic [DW-1:0] pd;
        sel = use_b;
        build_exp(use_b ? 2 : 1);
        total = exp_q.size();
        idx = 0; cyc = 0; dones = 0; first_v = -1; stall_left = 20; early_re = 0;
        pv = 1'b0; pd = '0; stop = 1'b0; restarted = 1'b0;
        @(negedge clk);
        start = 1'b1;
        rdy   = (rdy_mode == 0);
        while (!stop && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk({nm, " running"}, 64'(m_running), 64'd1);
            if (pv) chk({nm, " hold"}, {m_valid, m_data}, {1'b1, pd});
            if (m_valid && first_v < 0) begin
                first_v = cyc;
                chk({nm, " latency"}, 64'(cyc), 64'd3);
            end
            if (m_done) begin
                dones++;
                chk({nm, " done after last"}, 64'(idx), 64'(total));
                stop = 1'b1;
            end
            if (rdy_mode == 0) begin
                r = 1'b1;
            end else if (rdy_mode == 1) begin
                r = ($urandom_range(0, 1) == 1);
            end else if (first_v < 0 || stall_left > 0) begin
                early_re += int'(m_re);
                r = 1'b0;
                if (first_v >= 0) stall_left--;
            end else begin
                r = 1'b1;
            end
            rdy = r;
            if (m_valid && r) begin
                if (idx < total) chk({nm, " word"}, 64'(m_data), 64'(exp_q[idx]));
                else             chk({nm, " extra word"}, 64'(idx), 64'(total));
                idx++;
            end
            pv = m_valid && !r;
            pd = m_data;
            if (restart_at >= 0 && idx == restart_at && !restarted) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
            if (rst_at >= 0 && idx == rst_at) begin
                srst = 1'b1;
                @(negedge clk);
                chk({nm, " reset outputs"}, {m_valid, m_running, m_re, m_done, m_data},
                    64'd0);
                srst = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk({nm, " quiet after reset"}, {m_valid, m_re, m_running}, 64'd0);
                end
                stop = 1'b1;
            end
        end
        if (!stop) begin
            chk({nm, " timeout"}, 64'(cyc), 64'd0);
        end else if (rst_at < 0) begin
            chk({nm, " total words"}, 64'(idx), 64'(total));
            chk({nm, " done count"}, 64'(dones), 64'd1);
            if (rdy_mode == 2) chk({nm, " reads before stall end"}, 64'(early_re), 64'd2);
            @(negedge clk);
            chk({nm, " idle after done"}, {m_done, m_valid, m_running}, 64'd0);
        end
        rdy = 1'b0;
    endtask

    initial begin
        srst = 1'b1; start = 1'b0; rdy = 1'b0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset ctrl A", {a_running, a_done, a_re, a_valid}, 64'd0);
        chk("reset data A", {a_addr, a_data}, 64'd0);
        chk("reset ctrl B", {b_running, b_done, b_re, b_valid}, 64'd0);
        srst = 1'b0;
        @(negedge clk);

        run_stream("t1 ready",      1'b0, 0, -1, -1);
        run_stream("t2 random",     1'b0, 1, -1, -1);
        run_stream("t3 stall",      1'b0, 2, -1, -1);
        run_stream("t4 two groups", 1'b1, 0, -1, -1);
        run_stream("t5 reset",      1'b0, 1, 50, -1);
        run_stream("t5 replay",     1'b0, 0, -1, -1);
        run_stream("t6 restart",    1'b0, 1, -1, 30);

        // start coinciding with reset must not launch a stream
        sel = 1'b0;
        @(negedge clk);
        srst = 1'b1; start = 1'b1;
        @(negedge clk);
        srst = 1'b0; start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("start during reset", {a_running, a_valid, a_re}, 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
